// File: rtl/row_buffers_border_param.sv
// Row-buffer front end for vertical windows: keeps MASK_WIDTH-1 image rows,
// emits one MASK_WIDTH-tall column per advance with top/bottom border fill,
// and drains the bottom rows itself after the last pixel of a frame.
module row_buffers_border_param #(
    parameter int unsigned ROW_WIDTH  = 340,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned PIX_BIT    = 8,
    parameter int unsigned MASK_WIDTH = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      border_mode,
    input  logic                            pix_in_valid,
    output logic                            pix_in_ready,
    input  logic [PIX_BIT-1:0]              pix_in,
    output logic                            col_valid,
    output logic [PIX_BIT*MASK_WIDTH-1:0]   col_pix,
    output logic [$clog2(ROW_WIDTH)-1:0]    col_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]   col_y,
    output logic                            col_sof,
    output logic                            col_eof
);

    localparam int unsigned H  = (MASK_WIDTH - 1) / 2;
    localparam int unsigned NB = MASK_WIDTH - 1;
    localparam int unsigned XW = $clog2(ROW_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam int          HI = int'(H);
    localparam int          IH = int'(IMG_HEIGHT);
    localparam int          MW = int'(MASK_WIDTH);
    localparam int          RW = int'(ROW_WIDTH);
    localparam int          NBI = int'(NB);

    localparam logic [XW-1:0] XLast     = XW'(ROW_WIDTH - 1);
    localparam logic [YW-1:0] YLast     = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] YPrimeEnd = YW'(H - 1);

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StFlush} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [XW-1:0]       in_col_q, in_col_d;
    logic [YW-1:0]       in_row_q, in_row_d;
    logic [XW-1:0]       out_col_q, out_col_d;
    logic [YW-1:0]       out_row_q, out_row_d;
    logic                ready_q;
    logic                accept, advance, produce;
    logic [PIX_BIT-1:0]  shift_in;

    logic                            col_valid_q;
    logic [PIX_BIT*MASK_WIDTH-1:0]   col_pix_q, col_pix_d;
    logic [XW-1:0]                   col_x_q;
    logic [YW-1:0]                   col_y_q;
    logic                            col_sof_q, col_eof_q;

    // Row storage is deliberately unreset: out-of-image taps are always substituted.
    logic [PIX_BIT-1:0] line_q [NB][ROW_WIDTH];
    logic [PIX_BIT-1:0] raw    [MASK_WIDTH];

    assign pix_in_ready = ready_q;
    assign col_valid    = col_valid_q;
    assign col_pix      = col_pix_q;
    assign col_x        = col_x_q;
    assign col_y        = col_y_q;
    assign col_sof      = col_sof_q;
    assign col_eof      = col_eof_q;

    assign accept   = pix_in_valid & ready_q;
    assign advance  = accept | (state_q == StFlush);
    assign shift_in = (state_q == StFlush) ? '0 : pix_in;

    // Next-state, frame-mode capture and position counters.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        produce   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d  = border_mode;
                    state_d = (in_col_q == XLast && in_row_q == YPrimeEnd) ? StRun : StPrime;
                end
            end
            StPrime: begin
                if (accept && in_col_q == XLast && in_row_q == YPrimeEnd) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    produce = 1'b1;
                    if (in_col_q == XLast && in_row_q == YLast) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                produce = 1'b1;
                if (out_col_q == XLast && out_row_q == YLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            if (in_col_q == XLast) begin
                in_col_d = '0;
                in_row_d = (in_row_q == YLast) ? '0 : in_row_q + 1'b1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
        end

        if (produce) begin
            if (out_col_q == XLast) begin
                out_col_d = '0;
                out_row_d = (out_row_q == YLast) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    // Raw taps: tap 0 is the pixel entering now, tap k the pixel k rows above it.
    always_comb begin
        raw[0] = shift_in;
        for (int k = 1; k < MW; k++) begin
            raw[k] = line_q[k-1][RW-1];
        end
    end

    // Border substitution: out-of-image rows are redirected to a tap inside the window.
    always_comb begin
        int                 y, r, idx;
        logic               zero;
        logic [PIX_BIT-1:0] sel;
        col_pix_d = '0;
        y         = int'(out_row_q);
        for (int k = 0; k < MW; k++) begin
            r    = y + HI - k;
            idx  = k;
            zero = 1'b0;
            if (r < 0) begin
                case (mode_q)
                    2'd0:    zero = 1'b1;
                    2'd1:    idx  = HI + y;
                    default: idx  = 2 * y + 2 * HI - k;
                endcase
            end else if (r >= IH) begin
                case (mode_q)
                    2'd0:    zero = 1'b1;
                    2'd1:    idx  = HI + y - (IH - 1);
                    default: idx  = 2 * y + 2 * HI - 2 * (IH - 1) - k;
                endcase
            end
            sel = '0;
            for (int j = 0; j < MW; j++) begin
                if (j == idx) sel = raw[j];
            end
            col_pix_d[k*PIX_BIT +: PIX_BIT] = zero ? '0 : sel;
        end
    end

    // Cascaded row shift on every advance.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < NBI; k++) begin
                line_q[k][0] <= (k == 0) ? shift_in : line_q[k-1][RW-1];
                for (int j = 1; j < RW; j++) begin
                    line_q[k][j] <= line_q[k][j-1];
                end
            end
        end
    end

    // Control state and registered column output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= 2'd0;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            ready_q     <= 1'b0;
            col_valid_q <= 1'b0;
            col_pix_q   <= '0;
            col_x_q     <= '0;
            col_y_q     <= '0;
            col_sof_q   <= 1'b0;
            col_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            ready_q     <= (state_d != StFlush);
            col_valid_q <= produce;
            if (produce) begin
                col_pix_q <= col_pix_d;
                col_x_q   <= out_col_q;
                col_y_q   <= out_row_q;
                col_sof_q <= (out_col_q == '0) && (out_row_q == '0);
                col_eof_q <= (out_col_q == XLast) && (out_row_q == YLast);
            end
        end
    end

endmodule

// File: tb/tb_row_buffers_border_param.sv
module tb_row_buffers_border_param;

    localparam int RW = 4;
    localparam int IH = 5;
    localparam int MW = 3;
    localparam int PB = 8;
    localparam int H  = (MW - 1) / 2;
    localparam int NPIX = RW * IH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    border_mode = 2'd0;
    logic          pix_in_valid = 1'b0;
    logic          pix_in_ready;
    logic [PB-1:0] pix_in = '0;
    logic          col_valid;
    logic [PB*MW-1:0] col_pix;
    logic [1:0]    col_x;
    logic [2:0]    col_y;
    logic          col_sof, col_eof;

    row_buffers_border_param #(
        .ROW_WIDTH (RW),
        .IMG_HEIGHT(IH),
        .PIX_BIT   (PB),
        .MASK_WIDTH(MW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .border_mode (border_mode),
        .pix_in_valid(pix_in_valid),
        .pix_in_ready(pix_in_ready),
        .pix_in      (pix_in),
        .col_valid   (col_valid),
        .col_pix     (col_pix),
        .col_x       (col_x),
        .col_y       (col_y),
        .col_sof     (col_sof),
        .col_eof     (col_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PB*MW-1:0] pix;
        int               x;
        int               y;
        bit               sof;
        bit               eof;
    } col_t;

    int   checks = 0;
    int   errors = 0;
    logic [PB-1:0] img [IH][RW];
    col_t exp_q[$];
    int   acc_cnt = 0;
    int   last_acc = -1;
    bit   prev_ready = 1'b0;
    int   col_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Column for centre (x,y): tap k is image row y+H-k, out-of-image rows per border rule.
    function automatic logic [PB*MW-1:0] model_col(input logic [1:0] mode, input int x, input int y);
        logic [PB*MW-1:0] v;
        v = '0;
        for (int k = 0; k < MW; k++) begin
            int r;
            bit z;
            r = y + H - k;
            z = 1'b0;
            if (r < 0) begin
                if (mode == 2'd0) z = 1'b1;
                else if (mode == 2'd1) r = 0;
                else r = -r;
            end else if (r >= IH) begin
                if (mode == 2'd0) z = 1'b1;
                else if (mode == 2'd1) r = IH - 1;
                else r = 2 * (IH - 1) - r;
            end
            v[k*PB +: PB] = z ? '0 : img[r][x];
        end
        return v;
    endfunction

    // Accept tracking: index within frame of the pixel accepted at this edge.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            acc_cnt    = 0;
            last_acc   = -1;
            prev_ready = 1'b0;
        end else begin
            last_acc   = (pix_in_valid && pix_in_ready) ? acc_cnt : -1;
            prev_ready = pix_in_ready;
            if (pix_in_valid && pix_in_ready) acc_cnt = (acc_cnt + 1) % NPIX;
        end
    end

    // Output compare against the expected column stream.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (last_acc >= H * RW) chk("col_after_accept", 32'(col_valid), 32'd1);
            if (last_acc >= 0 && last_acc < H * RW) chk("prime_no_col", 32'(col_valid), 32'd0);
            if (col_valid) begin
                col_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_col: got col x=%0d y=%0d expected none", col_x, col_y);
                end else begin
                    col_t e;
                    int   c;
                    e = exp_q.pop_front();
                    chk("col_pix", 32'(col_pix), 32'(e.pix));
                    chk("col_x", 32'(col_x), e.x);
                    chk("col_y", 32'(col_y), e.y);
                    chk("col_sof", 32'(col_sof), 32'(e.sof));
                    chk("col_eof", 32'(col_eof), 32'(e.eof));
                    c = e.y * RW + e.x;
                    if (c < (IH - H) * RW) chk("col_latency", last_acc, c + H * RW);
                    else chk("flush_advance", 32'(prev_ready), 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(pix_in_ready), 32'd0);
        chk({tag, "_valid"}, 32'(col_valid), 32'd0);
        chk({tag, "_pix"}, 32'(col_pix), 32'd0);
        chk({tag, "_x"}, 32'(col_x), 32'd0);
        chk({tag, "_y"}, 32'(col_y), 32'd0);
        chk({tag, "_sof"}, 32'(col_sof), 32'd0);
        chk({tag, "_eof"}, 32'(col_eof), 32'd0);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < RW; c++) img[r][c] = 8'(16 * r + c);
    endtask

    task automatic run_frame(input logic [1:0] mode, input bit pattern, input bit gaps,
                             input int abort_at);
        int n, cyc, nf, start_total;
        bit acc;
        n = 0;
        cyc = 0;
        if (pattern) fill_pattern();
        else begin
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < RW; c++) img[r][c] = 8'($urandom);
        end
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < RW; x++)
                exp_q.push_back('{model_col(mode, x, y), x, y, (x == 0 && y == 0),
                                  (x == RW - 1 && y == IH - 1)});
        border_mode = mode;
        start_total = col_total;
        while (n < NPIX && cyc < 1000) begin
            pix_in       = img[n / RW][n % RW];
            pix_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            acc = pix_in_valid && pix_in_ready;
            #1;
            cyc++;
            if (acc) begin
                n++;
                if (gaps && n == 3) border_mode = 2'($urandom);
                if (n == abort_at) begin
                    reset = 1'b0;
                    pix_in_valid = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    exp_q.delete();
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                    return;
                end
            end
        end
        pix_in_valid = 1'b0;
        chk("frame_accepts", n, NPIX);
        nf = 0;
        while (!pix_in_ready && nf < 50) begin
            nf++;
            @(posedge clk);
            #1;
        end
        chk("flush_cycles", nf, H * RW);
        repeat (2) @(posedge clk);
        #1;
        chk("cols_per_frame", col_total - start_total, NPIX);
        chk("exp_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model on hand-computed border columns.
        fill_pattern();
        chk("pin_top_mirror", 32'(model_col(2'd2, 1, 0)), 32'h110111);
        chk("pin_top_repl", 32'(model_col(2'd1, 1, 0)), 32'h010111);
        chk("pin_top_zero", 32'(model_col(2'd0, 1, 0)), 32'h000111);
        chk("pin_bot_mirror", 32'(model_col(2'd2, 2, 4)), 32'h324232);
        chk("pin_bot_repl", 32'(model_col(2'd1, 2, 4)), 32'h324242);
        chk("pin_bot_zero", 32'(model_col(2'd0, 2, 4)), 32'h324200);

        run_frame(2'd2, 1'b1, 1'b0, -1);
        run_frame(2'd1, 1'b1, 1'b0, -1);
        run_frame(2'd0, 1'b1, 1'b0, -1);
        run_frame(2'd3, 1'b1, 1'b0, -1);
        for (int i = 0; i < 6; i++) run_frame(2'($urandom), 1'b0, 1'b1, -1);
        run_frame(2'd2, 1'b1, 1'b0, 9);
        run_frame(2'd0, 1'b1, 1'b0, -1);
        run_frame(2'd1, 1'b0, 1'b1, 7);
        run_frame(2'd1, 1'b0, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
